// File: rtl/regfile_uart_dump_pkg.sv
// Shared constants, FSM encoding and helpers for the register-file UART dump.
// Imported by the dump sequencer; the byte transmitter is self-contained.
package regfile_uart_dump_pkg;

    localparam logic [7:0] ASCII_R     = 8'h52;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_A     = 8'h41;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_WAIT,
        ST_FINISH
    } state_e;

    // Clocks per serial bit; never below one so the baud counter stays legal.
    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz / baud < 1) ? 1 : clk_hz / baud;
    endfunction

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return ASCII_0 + {4'h0, nib};
        end
        return ASCII_A + {4'h0, nib} - 8'd10;
    endfunction

endpackage

// File: rtl/regfile_uart_dump_uart_tx_byte.sv
// 8N1 byte transmitter: owns the baud counter and the 10-bit frame shifter.
// ready is high while idle; a byte is taken on valid & ready.
module uart_tx_byte #(
    parameter int DIV = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [9:0]       shift_q,    shift_d;
    logic [3:0]       bit_cnt_q,  bit_cnt_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic             active_q,   active_d;
    logic             tx_q,       tx_d;

    // NOTE: every signal gets a default at the top of the block, so no path can leave one unassigned and infer a latch.
    always_comb begin
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        baud_cnt_d = baud_cnt_q;
        active_d   = active_q;
        tx_d       = tx_q;
        if (!active_q) begin
            if (valid) begin
                shift_d    = {1'b1, data, 1'b0};
                bit_cnt_d  = '0;
                baud_cnt_d = '0;
                active_d   = 1'b1;
                tx_d       = 1'b0;
            end
        end else if (baud_cnt_q == CNT_LAST) begin
            baud_cnt_d = '0;
            if (bit_cnt_q == 4'd9) begin
                // Stop bit has run its full period: back to idle, line held high.
                active_d = 1'b0;
                tx_d     = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
                shift_d   = {1'b1, shift_q[9:1]};
                tx_d      = shift_q[1];
            end
        end else begin
            baud_cnt_d = baud_cnt_q + 1'b1;
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q    <= '1;
            bit_cnt_q  <= '0;
            baud_cnt_q <= '0;
            active_q   <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            baud_cnt_q <= baud_cnt_d;
            active_q   <= active_d;
            tx_q       <= tx_d;
        end
    end

    assign ready = ~active_q;
    assign tx    = tx_q;

endmodule

// File: rtl/regfile_uart_dump.sv
// Snapshots the packed register bus on start and prints one "Rn:HHHH\r\n"
// line per register over UART.
module regfile_uart_dump
    import regfile_uart_dump_pkg::*;
#(
    parameter int CLK_HZ   = 100000000,
    parameter int BAUD     = 115200,
    parameter int NUM_REGS = 8,
    parameter int WIDTH    = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [NUM_REGS*WIDTH-1:0] reg_bus,
    output logic                      tx,
    output logic                      busy,
    output logic                      done
);

    localparam int DIV        = calc_div(CLK_HZ, BAUD);
    localparam int HEX_DIGITS = WIDTH / 4;
    localparam int LINE_CHARS = HEX_DIGITS + 5;
    localparam int REG_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int CHAR_W     = $clog2(LINE_CHARS);

    localparam logic [REG_W-1:0]  REG_LAST = REG_W'(NUM_REGS - 1);
    localparam logic [CHAR_W-1:0] CHAR_CR  = CHAR_W'(HEX_DIGITS + 3);
    localparam logic [CHAR_W-1:0] CHAR_LF  = CHAR_W'(HEX_DIGITS + 4);

    state_e                    state_q,    state_d;
    logic [REG_W-1:0]          reg_idx_q,  reg_idx_d;
    logic [CHAR_W-1:0]         char_idx_q, char_idx_d;
    logic [7:0]                char_q,     char_d;
    logic                      busy_q,     busy_d;
    logic                      done_q,     done_d;
    logic [NUM_REGS*WIDTH-1:0] snap_q;
    logic                      snap_load;

    logic [WIDTH-1:0] regs [NUM_REGS];
    logic [WIDTH-1:0] cur_reg;
    logic [3:0]       nibble;
    logic [7:0]       next_char;
    logic             last_char;
    logic             tx_valid;
    logic             tx_ready;

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] = snap_q[i*WIDTH +: WIDTH];
        end
    end

    assign cur_reg   = regs[reg_idx_q];
    assign last_char = (reg_idx_q == REG_LAST) && (char_idx_q == CHAR_LF);
    assign tx_valid  = (state_q == ST_SEND);

    // Hex digits occupy line positions 3..HEX_DIGITS+2, most significant first.
    always_comb begin
        nibble = '0;
        for (int k = 0; k < HEX_DIGITS; k++) begin
            if (char_idx_q == CHAR_W'(k + 3)) begin
                nibble = cur_reg[WIDTH-1-4*k -: 4];
            end
        end
    end

    always_comb begin
        next_char = hex_ascii(nibble);
        if (char_idx_q == CHAR_W'(0)) begin
            next_char = ASCII_R;
        end else if (char_idx_q == CHAR_W'(1)) begin
            next_char = ASCII_0 + 8'(reg_idx_q);
        end else if (char_idx_q == CHAR_W'(2)) begin
            next_char = ASCII_COLON;
        end else if (char_idx_q == CHAR_CR) begin
            next_char = ASCII_CR;
        end else if (char_idx_q == CHAR_LF) begin
            next_char = ASCII_LF;
        end
    end

    always_comb begin
        state_d    = state_q;
        reg_idx_d  = reg_idx_q;
        char_idx_d = char_idx_q;
        char_d     = char_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        snap_load  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    snap_load  = 1'b1;
                    reg_idx_d  = '0;
                    char_idx_d = '0;
                    busy_d     = 1'b1;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                char_d  = next_char;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                // valid is held until the transmitter frees up, so the next
                // start bit follows the previous stop bit with a one-cycle gap.
                if (tx_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (last_char) begin
                    if (tx_ready) begin
                        state_d = ST_FINISH;
                    end
                end else begin
                    if (char_idx_q == CHAR_LF) begin
                        char_idx_d = '0;
                        reg_idx_d  = reg_idx_q + 1'b1;
                    end else begin
                        char_idx_d = char_idx_q + 1'b1;
                    end
                    state_d = ST_LOAD;
                end
            end
            ST_FINISH: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            reg_idx_q  <= '0;
            char_idx_q <= '0;
            char_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            reg_idx_q  <= reg_idx_d;
            char_idx_q <= char_idx_d;
            char_q     <= char_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // NOTE: the snapshot is deliberately left out of reset; it is always loaded on start before anything reads it.
    always_ff @(posedge clk) begin
        if (snap_load) begin
            snap_q <= reg_bus;
        end
    end

    uart_tx_byte #(
        .DIV(DIV)
    ) u_tx (
        .clk  (clk),
        .reset(reset),
        .data (char_q),
        .valid(tx_valid),
        .ready(tx_ready),
        .tx   (tx)
    );

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_regfile_uart_dump.sv
// Bench for regfile_uart_dump: decodes the serial line and compares the text
// against lines formatted directly from the register values.
module tb_regfile_uart_dump;

    localparam int CLK_HZ     = 16;
    localparam int BAUD       = 1;
    localparam int DIV        = CLK_HZ / BAUD;
    localparam int NUM_REGS   = 8;
    localparam int WIDTH      = 16;
    localparam int LINE_CHARS = WIDTH / 4 + 5;
    localparam int DUMP_CHARS = NUM_REGS * LINE_CHARS;
    localparam int FRAME      = 10 * DIV;

    logic                      clk;
    logic                      reset;
    logic                      start;
    logic [NUM_REGS*WIDTH-1:0] reg_bus;
    logic                      tx;
    logic                      busy;
    logic                      done;

    int n_checks;
    int n_pass;
    int mon_busy;
    int mon_dones;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    regfile_uart_dump #(
        .CLK_HZ  (CLK_HZ),
        .BAUD    (BAUD),
        .NUM_REGS(NUM_REGS),
        .WIDTH   (WIDTH)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .reg_bus(reg_bus),
        .tx     (tx),
        .busy   (busy),
        .done   (done)
    );

    task automatic step();
        @(negedge clk);
        if (busy === 1'b1) mon_busy++;
        if (done === 1'b1) mon_dones++;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    function automatic logic [NUM_REGS*WIDTH-1:0] rand_regs();
        logic [NUM_REGS*WIDTH-1:0] r;
        for (int i = 0; i < NUM_REGS; i++) r[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        return r;
    endfunction

    // Reference text: "R<i>:<hex>\r\n" per register, hex forced to upper case.
    function automatic void build_expected(input logic [NUM_REGS*WIDTH-1:0] regs);
        string      line;
        logic [7:0] c;
        exp_q.delete();
        for (int i = 0; i < NUM_REGS; i++) begin
            line = $sformatf("R%0d:%h", i, regs[i*WIDTH +: WIDTH]);
            for (int k = 0; k < line.len(); k++) begin
                c = line[k];
                if (c >= 8'h61 && c <= 8'h66) c = c - 8'h20;
                exp_q.push_back(c);
            end
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endfunction

    function automatic int count_diff(input int n);
        int bad = 0;
        if (got_q.size() != n) bad++;
        for (int i = 0; i < n; i++) begin
            if (i >= got_q.size() || i >= exp_q.size()) bad++;
            else if (got_q[i] !== exp_q[i]) bad++;
        end
        return bad;
    endfunction

    task automatic wait_tx_low(input int budget, output int waited, output bit ok);
        waited = 0;
        ok     = 1'b1;
        while (tx !== 1'b0) begin
            if (waited >= budget) begin
                ok = 1'b0;
                break;
            end
            step();
            waited++;
        end
    endtask

    // Entered on the first low sample of a start bit; leaves at mid stop bit.
    task automatic recv_byte(output logic [7:0] b, output bit frame_ok);
        bit start_ok;
        repeat (DIV / 2) step();
        start_ok = (tx === 1'b0);
        for (int j = 0; j < 8; j++) begin
            repeat (DIV) step();
            b[j] = tx;
        end
        repeat (DIV) step();
        frame_ok = start_ok && (tx === 1'b1);
    endtask

    task automatic recv_chars(input int n, input bit first_started,
                              output int max_gap, output int frame_errs, output bit timed_out);
        int         waited;
        bit         ok;
        bit         fok;
        logic [7:0] b;
        max_gap    = 0;
        frame_errs = 0;
        timed_out  = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (k > 0 || !first_started) begin
                wait_tx_low((k == 0) ? 4 * DIV : DIV, waited, ok);
                if (!ok) begin
                    timed_out = 1'b1;
                    return;
                end
                if (k > 0 && waited - DIV / 2 > max_gap) max_gap = waited - DIV / 2;
            end
            recv_byte(b, fok);
            got_q.push_back(b);
            if (!fok) frame_errs++;
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        reset   = 1'b0;
        start   = 1'b0;
        reg_bus = rand_regs();
        repeat (3) step();
        n_checks++;
        if ({tx, busy, done} !== 3'b100)
            $display("FAIL reset_state: tx/busy/done=%b required 100", {tx, busy, done});
        else n_pass++;
        reset = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            if ({tx, busy, done} !== 3'b100) bad++;
        end
        n_checks++;
        if (bad !== 0) $display("FAIL idle_hold: %0d cycles not idle, required 0", bad);
        else n_pass++;
    endtask

    task automatic test_first_line();
        logic [NUM_REGS*WIDTH-1:0] regs;
        logic [9:0]                frame_bits;
        logic [7:0]                b0;
        int                        waited, bad, mg, fe;
        bit                        ok, to;
        regs              = rand_regs();
        regs[WIDTH-1:0]   = 16'h1234;
        reg_bus           = regs;
        build_expected(regs);
        got_q.delete();
        start = 1'b1;
        step();
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) $display("FAIL busy_after_start: busy=%b required 1", busy);
        else n_pass++;
        wait_tx_low(2, waited, ok);
        n_checks++;
        if (!ok) $display("FAIL start_latency: tx=%b 3 cycles after start, required 0", tx);
        else n_pass++;
        frame_bits = {1'b1, exp_q[0], 1'b0};
        bad = 0;
        b0  = '0;
        for (int c = 0; c < FRAME; c++) begin
            if (tx !== frame_bits[c / DIV]) bad++;
            if (c % DIV == DIV / 2 && c / DIV >= 1 && c / DIV <= 8) b0[c / DIV - 1] = tx;
            if (c < FRAME - 1) step();
        end
        n_checks++;
        if (bad !== 0) $display("FAIL first_frame_bits: %0d wrong cycles, required 0 (frame %b)", bad, frame_bits);
        else n_pass++;
        got_q.push_back(b0);
        recv_chars(LINE_CHARS - 1, 1'b0, mg, fe, to);
        n_checks++;
        if (to || fe !== 0 || mg > 2)
            $display("FAIL first_line_framing: timeout=%0d frame_errs=%0d max_gap=%0d, required 0/0/<=2", to, fe, mg);
        else n_pass++;
        bad = count_diff(LINE_CHARS);
        n_checks++;
        if (bad !== 0) $display("FAIL first_line_text: %0d chars differ, required 0", bad);
        else n_pass++;
        reset = 1'b0;
        repeat (2) step();
        reset = 1'b1;
        step();
        n_checks++;
        if ({tx, busy, done} !== 3'b100)
            $display("FAIL first_line_abort: tx/busy/done=%b required 100", {tx, busy, done});
        else n_pass++;
    endtask

    task automatic test_patterns();
        logic [15:0]               pat [NUM_REGS];
        logic [NUM_REGS*WIDTH-1:0] regs;
        int                        mg, fe, bad;
        bit                        to;
        pat = '{16'h0000, 16'hFFFF, 16'hBEEF, 16'h00A5, 16'h8000, 16'h7FFF, 16'h1111, 16'hDEAD};
        for (int i = 0; i < NUM_REGS; i++) regs[i*WIDTH +: WIDTH] = pat[i];
        reg_bus = regs;
        build_expected(regs);
        got_q.delete();
        mon_dones = 0;
        mon_busy  = 0;
        pulse_start();
        recv_chars(DUMP_CHARS, 1'b0, mg, fe, to);
        repeat (20) step();
        n_checks++;
        if (to || fe !== 0) $display("FAIL patterns_framing: timeout=%0d frame_errs=%0d, required 0/0", to, fe);
        else n_pass++;
        bad = count_diff(DUMP_CHARS);
        n_checks++;
        if (bad !== 0) $display("FAIL patterns_text: %0d chars differ (got %0d chars), required 0", bad, got_q.size());
        else n_pass++;
        n_checks++;
        if (mg > 2) $display("FAIL patterns_gap: max gap %0d cycles, required <= 2", mg);
        else n_pass++;
        n_checks++;
        if (mon_dones !== 1) $display("FAIL patterns_done: %0d done pulses, required 1", mon_dones);
        else n_pass++;
        n_checks++;
        if (mon_busy < DUMP_CHARS * FRAME || mon_busy > DUMP_CHARS * FRAME + 3 + 2 * (DUMP_CHARS - 1) + 6)
            $display("FAIL patterns_busy_len: busy %0d cycles, required %0d..%0d", mon_busy,
                     DUMP_CHARS * FRAME, DUMP_CHARS * FRAME + 3 + 2 * (DUMP_CHARS - 1) + 6);
        else n_pass++;
        n_checks++;
        if ({tx, busy} !== 2'b10) $display("FAIL patterns_end_idle: tx/busy=%b required 10", {tx, busy});
        else n_pass++;
    endtask

    task automatic test_snapshot();
        logic [NUM_REGS*WIDTH-1:0] regs;
        int                        mg, fe, bad;
        bit                        to, to2;
        regs    = rand_regs();
        reg_bus = regs;
        build_expected(regs);
        got_q.delete();
        mon_dones = 0;
        pulse_start();
        reg_bus = '0;
        recv_chars(20, 1'b0, mg, fe, to);
        pulse_start();
        recv_chars(DUMP_CHARS - 20, 1'b0, mg, bad, to2);
        fe += bad;
        repeat (20) step();
        n_checks++;
        if (to || to2 || fe !== 0)
            $display("FAIL snapshot_framing: timeout=%0d/%0d frame_errs=%0d, required 0/0/0", to, to2, fe);
        else n_pass++;
        bad = count_diff(DUMP_CHARS);
        n_checks++;
        if (bad !== 0) $display("FAIL snapshot_text: %0d chars differ, required 0", bad);
        else n_pass++;
        n_checks++;
        if (mon_dones !== 1) $display("FAIL snapshot_done: %0d done pulses, required 1", mon_dones);
        else n_pass++;
    endtask

    task automatic test_reset_abort();
        logic [NUM_REGS*WIDTH-1:0] regs;
        int                        mg, fe, bad, waited;
        bit                        to, ok;
        regs    = rand_regs();
        reg_bus = regs;
        build_expected(regs);
        got_q.delete();
        pulse_start();
        recv_chars(5, 1'b0, mg, fe, to);
        wait_tx_low(DIV, waited, ok);
        n_checks++;
        if (!ok || to) $display("FAIL abort_reach_char5: char 5 start bit not seen (tx=%b), required 0", tx);
        else n_pass++;
        repeat (8 * DIV + DIV / 2) step();
        n_checks++;
        if (tx !== exp_q[5][7]) $display("FAIL abort_bit7: tx=%b required %b", tx, exp_q[5][7]);
        else n_pass++;
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({tx, busy, done} !== 3'b100)
            $display("FAIL async_reset: tx/busy/done=%b required 100", {tx, busy, done});
        else n_pass++;
        repeat (3) step();
        reset = 1'b1;
        repeat (5) step();
        n_checks++;
        if ({tx, busy, done} !== 3'b100)
            $display("FAIL after_reset_idle: tx/busy/done=%b required 100", {tx, busy, done});
        else n_pass++;
        regs    = rand_regs();
        reg_bus = regs;
        build_expected(regs);
        got_q.delete();
        mon_dones = 0;
        pulse_start();
        recv_chars(DUMP_CHARS, 1'b0, mg, fe, to);
        repeat (20) step();
        bad = count_diff(DUMP_CHARS);
        n_checks++;
        if (to || fe !== 0 || bad !== 0)
            $display("FAIL post_reset_dump: timeout=%0d frame_errs=%0d diff=%0d, required 0/0/0", to, fe, bad);
        else n_pass++;
        n_checks++;
        if (mon_dones !== 1) $display("FAIL post_reset_done: %0d done pulses, required 1", mon_dones);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [NUM_REGS*WIDTH-1:0] regs_a, regs_b;
        int                        mg, fe, bad, waited;
        bit                        to, ok;
        regs_a  = rand_regs();
        regs_b  = rand_regs();
        reg_bus = regs_a;
        build_expected(regs_a);
        got_q.delete();
        mon_dones = 0;
        start = 1'b1;
        step();
        recv_chars(DUMP_CHARS, 1'b0, mg, fe, to);
        bad = count_diff(DUMP_CHARS);
        n_checks++;
        if (to || fe !== 0 || bad !== 0)
            $display("FAIL b2b_first_dump: timeout=%0d frame_errs=%0d diff=%0d, required 0/0/0", to, fe, bad);
        else n_pass++;
        waited = 0;
        while (done !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        n_checks++;
        if (done !== 1'b1) $display("FAIL b2b_done_seen: done=%b required 1", done);
        else n_pass++;
        reg_bus = regs_b;
        build_expected(regs_b);
        got_q.delete();
        wait_tx_low(3, waited, ok);
        n_checks++;
        if (!ok) $display("FAIL b2b_restart_latency: tx=%b 3 cycles after done, required 0", tx);
        else n_pass++;
        start = 1'b0;
        recv_chars(DUMP_CHARS, 1'b1, mg, fe, to);
        repeat (20) step();
        bad = count_diff(DUMP_CHARS);
        n_checks++;
        if (to || fe !== 0 || bad !== 0)
            $display("FAIL b2b_second_dump: timeout=%0d frame_errs=%0d diff=%0d, required 0/0/0", to, fe, bad);
        else n_pass++;
        n_checks++;
        if (mon_dones !== 2) $display("FAIL b2b_done_count: %0d done pulses, required 2", mon_dones);
        else n_pass++;
        n_checks++;
        if ({tx, busy} !== 2'b10) $display("FAIL b2b_end_idle: tx/busy=%b required 10", {tx, busy});
        else n_pass++;
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        mon_busy  = 0;
        mon_dones = 0;
        reset     = 1'b0;
        start     = 1'b0;
        reg_bus   = '0;
        test_reset();
        test_first_line();
        test_patterns();
        test_snapshot();
        test_reset_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", n_pass, n_checks);
        $fatal(1, "time limit");
    end

endmodule
